// File: rtl/fib_stack_ctrl_pkg.sv
// Shared types and constants for the stack-driven Fibonacci-style controller.
package fib_stack_ctrl_pkg;

  localparam int DATA_W      = 64;
  localparam int IDX_W       = 6;
  localparam int LEAF_THRESH = 2;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_N,
    CHECK,
    EVAL,
    PUSH2,
    DONE
  } state_t;

endpackage

// File: rtl/fib_stack_ctrl.sv
// Computes G(n) = G(n-1) + G(n-2) by depth-first expansion on an external LIFO.
// Optional macro FIB_OVF_DETECT_EN: saturate acc on carry-out and raise sticky ovf.
module fib_stack_ctrl
  import fib_stack_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IDX_W-1:0]    n,
  input  logic [DATA_W-1:0]   base0,
  input  logic [DATA_W-1:0]   base1,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic                ovf,
  output logic                stk_push,
  output logic                stk_pop,
  output logic                stk_top,
  output logic [DATA_W-1:0]   stk_din,
  input  logic [DATA_W-1:0]   stk_dout,
  input  logic                stk_empty
);

  state_t              state;
  logic [IDX_W-1:0]    n_r;
  logic [IDX_W-1:0]    x;
  logic [DATA_W-1:0]   base0_r;
  logic [DATA_W-1:0]   base1_r;
  logic [DATA_W-1:0]   acc;

  logic [IDX_W-1:0]    x_in;
  logic                is_leaf;
  logic [DATA_W-1:0]   addend;
  logic [DATA_W:0]     sum;
  logic                unused_dout_bits;

  // Only the low index bits of a popped word carry meaning.
  assign x_in             = stk_dout[IDX_W-1:0];
  assign unused_dout_bits = ^stk_dout[DATA_W-1:IDX_W];
  assign is_leaf          = (x_in < IDX_W'(LEAF_THRESH));
  assign addend           = (x_in == '0) ? base0_r : base1_r;
  assign sum              = {1'b0, acc} + {1'b0, addend};

`ifndef FIB_OVF_DETECT_EN
  logic unused_carry;
  assign unused_carry = sum[DATA_W];
`endif

  assign stk_push = (state == PUSH_N) || (state == PUSH2) || ((state == EVAL) && !is_leaf);
  assign stk_pop  = (state == CHECK) && !stk_empty;
  assign stk_top  = 1'b0;

  always_comb begin
    stk_din = '0;
    case (state)
      PUSH_N:  stk_din = {{(DATA_W-IDX_W){1'b0}}, n_r};
      EVAL:    stk_din = {{(DATA_W-IDX_W){1'b0}}, x_in - IDX_W'(1)};
      PUSH2:   stk_din = {{(DATA_W-IDX_W){1'b0}}, x - IDX_W'(2)};
      default: stk_din = '0;
    endcase
  end

  // Leaves add their base value into acc; inner nodes expand into two children.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      result  <= '0;
      acc     <= '0;
      x       <= '0;
      n_r     <= '0;
      base0_r <= '0;
      base1_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && stk_empty) begin
            n_r     <= n;
            base0_r <= base0;
            base1_r <= base1;
            acc     <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= PUSH_N;
          end
        end
        PUSH_N: state <= CHECK;
        CHECK: begin
          if (stk_empty) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc;
            state  <= DONE;
          end else begin
            state <= EVAL;
          end
        end
        EVAL: begin
          x <= x_in;
          if (is_leaf) begin
`ifdef FIB_OVF_DETECT_EN
            if (sum[DATA_W]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= sum[DATA_W-1:0];
            end
`else
            acc <= sum[DATA_W-1:0];
`endif
            state <= CHECK;
          end else begin
            state <= PUSH2;
          end
        end
        PUSH2: state <= CHECK;
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
